nibble_serial_subtractor: RTL and testbench
===========================================

# nibble_serial_subtractor

Multi-cycle two's-complement subtractor. It computes `diff = a - b - borrow_in` one 4-bit nibble per clock. Each nibble uses a borrow-select slice: both borrow-in cases are precomputed and a registered borrow picks one. It is the subtract/inverse-direction companion to the combinational carry-select adder, and sits on the datapath behind a valid/ready handshake so that wide operands stay within timing.

## Interface
- `WIDTH`, 16, operand and result width in bits; must be a multiple of 4 and ≥ 8.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low. The block has one clock.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `borrow_in` input 1: borrow into nibble 0.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts result.
- `diff` output WIDTH: `a - b - borrow_in`, modulo 2^WIDTH.
- `borrow_out` output 1: borrow out of the MSB nibble; 1 iff unsigned `a < b + borrow_in`.
- `overflow` output 1: signed overflow. Present only when `NSS_OVERFLOW_EN` is defined.

## Operation
- NIB = WIDTH/4. A nibble index counter is sized `$clog2(NIB)`, minimum 1 bit.
- State machine has three states.
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `a`, `b` and `borrow_in` into internal registers. Clear the index and the `diff` register, then go to BUSY.
  - BUSY: `in_ready`=0. Each cycle, the slice for nibble `idx` computes `d0 = a_n - b_n` and `d1 = a_n - b_n - 1`, each with a borrow.
    - The registered borrow selects the pair. The selected nibble is written into `diff[4*idx +: 4]` and the selected borrow is registered.
    - `idx` increments each cycle. When `idx == NIB-1`, go to DONE.
  - DONE: `out_valid`=1, `in_ready`=0. `diff` and `borrow_out` hold stable. On `out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; no operands are queued.
- Latched operands are used throughout the operation. Changes on the input ports after acceptance have no effect.
- Reset values: state IDLE, `in_ready`=1 (combinational from state), `out_valid`=0, `diff`=0, `borrow_out`=0, `overflow`=0, index=0, internal borrow=0.
- Reset mid-operation: the operation is abandoned with no output. After `rst_n` deasserts, the block is in IDLE with reset values.

## Timing
- Operands are accepted on edge E0. The BUSY edges are E1..E_NIB.
- `out_valid` rises after E_NIB, i.e. NIB cycles after acceptance (4 cycles for WIDTH=16).
- `out_valid` and `in_ready` are never both 1.
- Minimum issue interval is NIB+2 cycles, with `out_ready` tied high.
- The result is consumed on the edge where `out_valid && out_ready`. `in_ready` is 1 in the next cycle.
- Backpressure: DONE is held for any number of cycles, and outputs do not change while held.
- `borrow_out` and `overflow` are updated on the same edge as the final `diff` nibble.

## Configuration
- `NSS_OVERFLOW_EN` defined:
  - `overflow` port exists.
  - `overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the latched `a` and `b`.
  - It is registered on entry to DONE and cleared on acceptance of the next operands.
- Not defined: no `overflow` port and no MSB tracking logic.

## Structure
- Package `nss_pkg` contains:
  - the state enum `nss_state_t` {IDLE, BUSY, DONE};
  - nibble width constant `NSS_NIB_W` = 4.
- Sub-module `borrow_select4` is a combinational 4-bit slice:
  - inputs `a_n`, `b_n`, `bsel`;
  - outputs `d`, `bout`;
  - contains two ripple subtractors (borrow-in 0 and 1) and a 2:1 select.
- The top level holds the FSM, index counter, operand registers, borrow register and `diff` register.

## Test plan
All cases use WIDTH=16.
- `a`=0x1234, `b`=0x0234, `borrow_in`=0, `out_ready`=1 → `diff`=0x1000, `borrow_out`=0, `out_valid` exactly 4 cycles after acceptance, high for 1 cycle.
- `a`=0x1000, `b`=0x0001, `borrow_in`=0 → borrow ripples across nibbles; `diff`=0x0FFF, `borrow_out`=0.
- `a`=0x0005, `b`=0x0005, `borrow_in`=1 → `diff`=0xFFFF, `borrow_out`=1.
- Backpressure: `a`=0x0000, `b`=0x0001, `out_ready` low for 3 cycles after `out_valid` → `diff`=0xFFFF and `borrow_out`=1 held stable, `in_ready`=0. A new `in_valid` pulse during this period is ignored. `in_ready`=1 the cycle after the handshake.
- Reset asserted 2 cycles into BUSY → `out_valid`=0, `diff`=0 immediately. After release, `in_ready`=1 and the next operation completes correctly.
- With `NSS_OVERFLOW_EN`: `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `overflow`=1. Then `a`=0x0003, `b`=0x0001 → `diff`=0x0002, `overflow`=0.

Source files
------------

// File: rtl/nibble_serial_subtractor_pkg.sv
// nss_pkg: shared types and constants for nibble_serial_subtractor.
//   nss_state_t : controller state encoding (IDLE, BUSY, DONE)
//   NSS_NIB_W   : width of one serial slice in bits
package nss_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } nss_state_t;

  localparam int NSS_NIB_W = 4;

endpackage

// File: rtl/nibble_serial_subtractor_borrow_select4.sv
// borrow_select4: combinational 4-bit borrow-select subtract slice.
// Both borrow-in cases are rippled in parallel; bsel picks the pair.
//   a_n  [3:0] in  : minuend nibble
//   b_n  [3:0] in  : subtrahend nibble
//   bsel       in  : borrow into this nibble
//   d    [3:0] out : a_n - b_n - bsel (mod 16)
//   bout       out : borrow out of this nibble
module borrow_select4
  import nss_pkg::*;
(
  input  logic [NSS_NIB_W-1:0] a_n,
  input  logic [NSS_NIB_W-1:0] b_n,
  input  logic                 bsel,
  output logic [NSS_NIB_W-1:0] d,
  output logic                 bout
);

  // Returns {borrow_out, difference} of a bit-level ripple subtractor.
  function automatic logic [NSS_NIB_W:0] ripple_sub(
    input logic [NSS_NIB_W-1:0] x,
    input logic [NSS_NIB_W-1:0] y,
    input logic                 bin
  );
    logic [NSS_NIB_W-1:0] r;
    logic                 br;
    br = bin;
    r  = '0;
    for (int i = 0; i < NSS_NIB_W; i++) begin
      r[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, r};
  endfunction

  logic [NSS_NIB_W:0] res0;
  logic [NSS_NIB_W:0] res1;

  assign res0 = ripple_sub(a_n, b_n, 1'b0);
  assign res1 = ripple_sub(a_n, b_n, 1'b1);

  assign d    = bsel ? res1[NSS_NIB_W-1:0] : res0[NSS_NIB_W-1:0];
  assign bout = bsel ? res1[NSS_NIB_W]     : res0[NSS_NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: multi-cycle a - b - borrow_in, one nibble per
// clock, behind a valid/ready handshake.
//   clk, rst_n (async, active-low)
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b [WIDTH-1:0]    : minuend / subtrahend, latched on acceptance
//   borrow_in           : borrow into nibble 0
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   diff [WIDTH-1:0]    : a - b - borrow_in mod 2^WIDTH
//   borrow_out          : 1 iff unsigned a < b + borrow_in
//   overflow            : signed overflow; only with NSS_OVERFLOW_EN defined
// WIDTH must be a multiple of 4 and >= 8.
module nibble_serial_subtractor
  import nss_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef NSS_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NIB   = WIDTH / NSS_NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  nss_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovalid_q, ovalid_d;
`ifdef NSS_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NSS_NIB_W-1:0] slice_d;
  logic                 slice_bout;
  logic [IDX_W+1:0]     base;

  // Bit offset of the current nibble (idx * 4).
  assign base = {idx_q, 2'b00};

  borrow_select4 u_slice (
    .a_n  (a_q[base +: NSS_NIB_W]),
    .b_n  (b_q[base +: NSS_NIB_W]),
    .bsel (bor_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    bor_d    = bor_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovalid_d = ovalid_q;
`ifdef NSS_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          bor_d   = borrow_in;
          idx_d   = '0;
          diff_d  = '0;
`ifdef NSS_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        diff_d[base +: NSS_NIB_W] = slice_d;
        bor_d = slice_bout;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          // Final nibble: borrow/overflow land on the same edge as diff MSBs.
          state_d  = DONE;
          ovalid_d = 1'b1;
          bout_d   = slice_bout;
`ifdef NSS_OVERFLOW_EN
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (slice_d[NSS_NIB_W-1] != a_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          ovalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bor_q    <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovalid_q <= 1'b0;
`ifdef NSS_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bor_q    <= bor_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovalid_q <= ovalid_d;
`ifdef NSS_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = ovalid_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef NSS_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Testbench for nibble_serial_subtractor (WIDTH=16). Overflow scenario
// is exercised when NSS_OVERFLOW_EN is defined.
module tb_nibble_serial_subtractor;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             borrow_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef NSS_OVERFLOW_EN
  logic             overflow;
`endif

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef NSS_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Drive one operand set (caller ensures the DUT is idle); push the
  // reference result. Returns at posedge+1 of the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ibin);
    exp_t        e;
    logic [WIDTH:0] full;
    full   = {1'b0, ia} - {1'b0, ib} - (WIDTH+1)'(ibin);
    e.diff = full[WIDTH-1:0];
    e.bout = full[WIDTH];
    e.ovf  = (ia[WIDTH-1] != ib[WIDTH-1]) && (full[WIDTH-1] != ia[WIDTH-1]);
    a = ia; b = ib; borrow_in = ibin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble ports: the DUT must work from latched operands.
    a = WIDTH'($urandom); b = WIDTH'($urandom); borrow_in = ~ibin;
    sb.push_back(e);
  endtask

  // Count clock edges until out_valid is seen (bounded).
  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (diff !== '0) begin errors++; $display("FAIL reset_diff got %h want 0000", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow_out got %b want 0", borrow_out); end
`ifdef NSS_OVERFLOW_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  logic [WIDTH-1:0] basic_a[3] = '{16'h1234, 16'h1000, 16'h0005};
  logic [WIDTH-1:0] basic_b[3] = '{16'h0234, 16'h0001, 16'h0005};
  logic             basic_c[3] = '{1'b0, 1'b0, 1'b1};

  task automatic test_basic();
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic%0d_in_ready got %b want 1", i, in_ready); end
      issue(basic_a[i], basic_b[i], basic_c[i]);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic%0d_busy_in_ready got %b want 0", i, in_ready); end
      wait_out(cyc);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL basic%0d_timeout out_valid got %b want 1", i, out_valid);
      end else begin
        if (cyc != LAT) begin errors++; $display("FAIL basic%0d_latency got %0d want %0d", i, cyc, LAT); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic%0d_done_in_ready got %b want 0", i, in_ready); end
        checks++; if (diff !== e.diff) begin errors++; $display("FAIL basic%0d_diff got %h want %h", i, diff, e.diff); end
        checks++; if (borrow_out !== e.bout) begin errors++; $display("FAIL basic%0d_borrow got %b want %b", i, borrow_out, e.bout); end
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic%0d_valid_one_cycle got %b want 0", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic%0d_ready_after got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int   cyc;
    exp_t e;
    out_ready = 1'b0;
    issue(16'h0000, 16'h0001, 1'b0);
    wait_out(cyc);
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout out_valid got %b want 1", out_valid); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_valid got %b want 1", k, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_in_ready got %b want 0", k, in_ready); end
      checks++; if (diff !== e.diff) begin errors++; $display("FAIL bp_hold%0d_diff got %h want %h", k, diff, e.diff); end
      checks++; if (borrow_out !== e.bout) begin errors++; $display("FAIL bp_hold%0d_borrow got %b want %b", k, borrow_out, e.bout); end
      if (k == 1) begin a = 16'h1111; b = 16'h0000; borrow_in = 1'b0; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    checks++; if (diff !== 16'hFFFF) begin errors++; $display("FAIL bp_final_diff got %h want ffff", diff); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b want 0", out_valid); end
    // The ignored pulse must not produce a result later.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_queue%0d got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_reset_midop();
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    issue(16'hABCD, 16'h1234, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if (diff !== '0) begin errors++; $display("FAIL midrst_diff got %h want 0000", diff); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_release_valid got %b want 0", out_valid); end
    issue(16'hFFFF, 16'h0001, 1'b1);
    wait_out(cyc);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_timeout out_valid got %b want 1", out_valid);
    end else begin
      if (cyc != LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", cyc, LAT); end
      checks++; if (diff !== e.diff) begin errors++; $display("FAIL midrst_diff_after got %h want %h", diff, e.diff); end
      checks++; if (borrow_out !== e.bout) begin errors++; $display("FAIL midrst_borrow_after got %b want %b", borrow_out, e.bout); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready got %b want 1", i, in_ready); end
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      wait_out(cyc);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b%0d_timeout out_valid got %b want 1", i, out_valid);
      end else begin
        checks++; if (diff !== e.diff) begin errors++; $display("FAIL b2b%0d_diff got %h want %h", i, diff, e.diff); end
        checks++; if (borrow_out !== e.bout) begin errors++; $display("FAIL b2b%0d_borrow got %b want %b", i, borrow_out, e.bout); end
`ifdef NSS_OVERFLOW_EN
        checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL b2b%0d_overflow got %b want %b", i, overflow, e.ovf); end
`endif
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef NSS_OVERFLOW_EN
  task automatic test_overflow();
    int   cyc;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue(16'h8000, 16'h0001, 1'b0);
      else        issue(16'h0003, 16'h0001, 1'b0);
      wait_out(cyc);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL ovf%0d_timeout out_valid got %b want 1", i, out_valid);
      end else begin
        checks++; if (diff !== e.diff) begin errors++; $display("FAIL ovf%0d_diff got %h want %h", i, diff, e.diff); end
        checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL ovf%0d_flag got %b want %b", i, overflow, e.ovf); end
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
`ifdef NSS_OVERFLOW_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
